// File: rtl/usb_rx_pkg.sv
// Shared USB 1.1 receive-path types and constants.
package usb_rx_pkg;

  localparam int USB_STUFF_LEN = 6;
  localparam int USB_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    ERROR
  } rx_bit_state_t;

endpackage

// File: rtl/usb_rx_bit_ctrl.sv
// RX bit sequencer: strips stuffed bits, drives the byte shift register's
// shift enable, counts bits per byte and flags stuffing/alignment errors.
module usb_rx_bit_ctrl
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int BYTE_BITS = USB_BYTE_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rcving,
  input  logic                         bit_strobe,
  input  logic                         d_orig,
  output logic                         shift_en,
  output logic                         byte_ready,
  output logic [$clog2(BYTE_BITS)-1:0] bit_cnt,
  output logic                         stuff_err,
  output logic                         align_err
);

  localparam int CNT_W  = $clog2(BYTE_BITS);
  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  rx_bit_state_t     state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
  logic              byte_ready_q, byte_ready_d;
  logic              stuff_err_q, stuff_err_d;
  logic              align_err_q, align_err_d;
  logic              stuff_pos;

  // After STUFF_LEN ones the next bit must be a stuffed 0 and is never shifted.
  assign stuff_pos = (ones_cnt_q == ONES_W'(STUFF_LEN));
  assign shift_en  = bit_strobe & (state_q == RECEIVE) & rcving & ~stuff_pos;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    stuff_err_d  = stuff_err_q;
    byte_ready_d = 1'b0;
    align_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rcving) begin
          state_d     = RECEIVE;
          bit_cnt_d   = '0;
          ones_cnt_d  = '0;
          stuff_err_d = 1'b0;
        end
      end
      RECEIVE: begin
        // A falling rcving outranks a coincident strobe; that bit is dropped.
        if (!rcving) begin
          state_d     = IDLE;
          align_err_d = (bit_cnt_q != '0);
        end else if (bit_strobe) begin
          if (stuff_pos) begin
            if (d_orig) begin
              stuff_err_d = 1'b1;
              state_d     = ERROR;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            if (bit_cnt_q == CNT_W'(BYTE_BITS - 1)) begin
              bit_cnt_d    = '0;
              byte_ready_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            ones_cnt_d = d_orig ? ones_cnt_q + ONES_W'(1) : '0;
          end
        end
      end
      ERROR: begin
        if (!rcving) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      byte_ready_q <= byte_ready_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign bit_cnt    = bit_cnt_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_usb_rx_bit_ctrl.sv
// Directed bench for usb_rx_bit_ctrl with a behavioural LSB-first shift register.
module tb_usb_rx_bit_ctrl;

  logic       clk = 1'b0;
  logic       rst, rcving, bit_strobe, d_orig;
  logic       shift_en, byte_ready, stuff_err, align_err;
  logic [2:0] bit_cnt;
  logic [7:0] sr;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_br    = 0;
  int         n_ae    = 0;

  always #5 clk = ~clk;

  usb_rx_bit_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rcving    (rcving),
    .bit_strobe(bit_strobe),
    .d_orig    (d_orig),
    .shift_en  (shift_en),
    .byte_ready(byte_ready),
    .bit_cnt   (bit_cnt),
    .stuff_err (stuff_err),
    .align_err (align_err)
  );

  // Shift register beside the controller: first bit lands in bit 0.
  always @(posedge clk) if (shift_en) sr <= {d_orig, sr[7:1]};

  always @(negedge clk) begin
    if (byte_ready) n_br++;
    if (align_err)  n_ae++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with strobe low.
  task automatic send_bit(input logic b, input logic exp_se, input string tag);
    bit_strobe = 1'b1;
    d_orig     = b;
    #1 chk(tag, 32'(shift_en), 32'(exp_se));
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input string tag);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b1, tag);
  endtask

  task automatic start_pkt();
    rcving     = 1'b1;
    bit_strobe = 1'b1;
    d_orig     = 1'b1;
    #1 chk("idle_strobe_ignored", 32'(shift_en), 32'd0);
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rcving = 1'b0; bit_strobe = 1'b0; d_orig = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_bit_cnt",    32'(bit_cnt),    32'd0);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_stuff_err",  32'(stuff_err),  32'd0);
    chk("rst_align_err",  32'(align_err),  32'd0);
    chk("rst_shift_en",   32'(shift_en),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain byte 0x4D
    start_pkt();
    send_byte(8'h4D, "t1_shift");
    chk("t1_byte_ready", 32'(byte_ready), 32'd1);
    chk("t1_byte_data",  32'(sr),         32'h4D);
    chk("t1_bit_cnt",    32'(bit_cnt),    32'd0);
    @(negedge clk);
    chk("t1_ready_single", 32'(byte_ready), 32'd0);
    rcving = 1'b0;
    @(negedge clk);
    chk("t1_no_align", 32'(align_err), 32'd0);

    // Six ones, stuffed zero, then 0,1 -> 0xBF
    start_pkt();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, "t2_ones");
    send_bit(1'b0, 1'b0, "t2_stuffed");
    chk("t2_cnt_hold", 32'(bit_cnt), 32'd6);
    send_bit(1'b0, 1'b1, "t2_b6");
    send_bit(1'b1, 1'b1, "t2_b7");
    chk("t2_byte_ready", 32'(byte_ready), 32'd1);
    chk("t2_byte_data",  32'(sr),         32'hBF);
    chk("t2_bit_cnt",    32'(bit_cnt),    32'd0);
    rcving = 1'b0;
    @(negedge clk);

    // Seven ones: stuff error, then strobes ignored until rcving drops
    start_pkt();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, "t3_ones");
    send_bit(1'b1, 1'b0, "t3_bad_stuff");
    chk("t3_stuff_err", 32'(stuff_err), 32'd1);
    send_bit(1'b0, 1'b0, "t3_err_ignore0");
    send_bit(1'b1, 1'b0, "t3_err_ignore1");
    rcving = 1'b0;
    @(negedge clk);
    chk("t3_err_no_align", 32'(align_err), 32'd0);
    chk("t3_err_sticky",   32'(stuff_err), 32'd1);
    start_pkt();
    chk("t3_err_cleared", 32'(stuff_err), 32'd0);
    chk("t3_cnt_cleared", 32'(bit_cnt),   32'd0);

    // Partial byte at EOP (continues the packet just started)
    send_bit(1'b1, 1'b1, "t4_bit"); send_bit(1'b0, 1'b1, "t4_bit");
    send_bit(1'b1, 1'b1, "t4_bit"); send_bit(1'b0, 1'b1, "t4_bit");
    send_bit(1'b1, 1'b1, "t4_bit");
    chk("t4_bit_cnt", 32'(bit_cnt), 32'd5);
    rcving = 1'b0;
    @(negedge clk);
    chk("t4_align_err", 32'(align_err),  32'd1);
    chk("t4_no_ready",  32'(byte_ready), 32'd0);
    @(negedge clk);
    chk("t4_align_single", 32'(align_err), 32'd0);
    send_bit(1'b1, 1'b0, "t4_idle_strobe");

    // rcving falls together with the 8th strobe
    start_pkt();
    for (int i = 0; i < 7; i++) send_bit(1'(i & 1), 1'b1, "t5_bit");
    chk("t5_bit_cnt", 32'(bit_cnt), 32'd7);
    rcving = 1'b0;
    send_bit(1'b1, 1'b0, "t5_drop_bit");
    chk("t5_align_err", 32'(align_err),  32'd1);
    chk("t5_no_ready",  32'(byte_ready), 32'd0);
    @(negedge clk);

    // Reset after three bits, then a clean 0xA5
    start_pkt();
    send_bit(1'b1, 1'b1, "t6_bit"); send_bit(1'b1, 1'b1, "t6_bit");
    send_bit(1'b0, 1'b1, "t6_bit");
    rst = 1'b1; rcving = 1'b0;
    @(negedge clk);
    chk("t6_rst_cnt",   32'(bit_cnt),   32'd0);
    chk("t6_rst_align", 32'(align_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_align", 32'(align_err), 32'd0);
    start_pkt();
    send_byte(8'hA5, "t6_shift");
    chk("t6_byte_ready", 32'(byte_ready), 32'd1);
    chk("t6_byte_data",  32'(sr),         32'hA5);
    rcving = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("total_byte_ready", 32'(n_br), 32'd3);
    chk("total_align_err",  32'(n_ae), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
